// File: rtl/instru_mem_sync.sv
`default_nettype none
// ============================================================================
// Module      : instru_mem_sync
// Description : Clocked instruction memory. A DEPTH-entry word array is filled
//               sequentially through a loader port and read through a
//               registered one-cycle fetch with stall hold. Misaligned,
//               out-of-range and not-yet-loaded fetches return NOP and a
//               fault code.
// Ports       : clk, rst_n            - clock, async active-low reset
//               a, req, stall         - fetch address (PC), request, stall
//               rd, rd_valid, fault   - registered fetch result and status
//                                       (fault: 0 ok, 1 misaligned,
//                                        2 out of range, 3 unloaded)
//               ld_clr, ld_valid,     - loader rewind, write strobe, data
//               ld_data
//               ld_full, ld_count     - loader status
// Revision    : 1.0 - initial release
// ============================================================================
module instru_mem_sync #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 32,
    parameter int               AW        = 32,
    parameter bit               BYTE_ADDR = 1'b1,
    parameter logic [WIDTH-1:0] NOP       = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AW-1:0]              a,
    input  logic                       req,
    input  logic                       stall,
    output logic [WIDTH-1:0]           rd,
    output logic                       rd_valid,
    output logic [1:0]                 fault,
    input  logic                       ld_clr,
    input  logic                       ld_valid,
    input  logic [WIDTH-1:0]           ld_data,
    output logic                       ld_full,
    output logic [$clog2(DEPTH+1)-1:0] ld_count
);

    localparam int CW  = $clog2(DEPTH + 1);               // loader counter width
    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1; // array index width
    localparam int IW  = BYTE_ADDR ? (AW - 2) : AW;       // fetch index width
    // Comparison width wide enough for the full index, the counter and DEPTH,
    // so an index is never truncated before the range checks.
    localparam int XW  = ((IW > CW) ? IW : CW) + 1;

    localparam logic [1:0] c_fault_none  = 2'd0;
    localparam logic [1:0] c_fault_align = 2'd1;
    localparam logic [1:0] c_fault_range = 2'd2;
    localparam logic [1:0] c_fault_unld  = 2'd3;

    localparam logic [XW-1:0] c_depth_x = XW'(DEPTH);
    localparam logic [CW-1:0] c_depth_c = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_ld_count;
    logic [WIDTH-1:0] r_rd;
    logic             r_rd_valid;
    logic [1:0]       r_fault;

    logic [IW-1:0]    w_idx;
    logic             w_misaligned;
    logic [XW-1:0]    w_idx_x;
    logic [XW-1:0]    w_cnt_x;
    logic [1:0]       w_fault;
    logic             w_ld_full;
    logic             w_ld_we;
    logic [MAW-1:0]   w_ld_addr;
    logic [CW-1:0]    w_ld_count_nxt;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    generate
        if (BYTE_ADDR) begin : g_byte_addr
            assign w_idx        = a[AW-1:2];
            assign w_misaligned = (a[1:0] != 2'b00);
        end else begin : g_word_addr
            assign w_idx        = a;
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_idx_x = XW'(w_idx);
    assign w_cnt_x = XW'(r_ld_count);

    // Priority: misaligned, out of range, unloaded. The unloaded check uses
    // the count before this cycle's load, so an entry written this cycle is
    // not yet fetchable.
    always_comb begin
        w_fault = c_fault_none;
        if (w_misaligned) begin
            w_fault = c_fault_align;
        end else if (w_idx_x >= c_depth_x) begin
            w_fault = c_fault_range;
        end else if (w_idx_x >= w_cnt_x) begin
            w_fault = c_fault_unld;
        end
    end

    // ------------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------------
    assign w_ld_full = (r_ld_count == c_depth_c);

    // ld_clr rewinds first, so a simultaneous ld_valid always lands in entry 0.
    always_comb begin
        w_ld_we        = 1'b0;
        w_ld_addr      = r_ld_count[MAW-1:0];
        w_ld_count_nxt = r_ld_count;
        if (ld_clr) begin
            w_ld_addr      = '0;
            w_ld_we        = ld_valid;
            w_ld_count_nxt = ld_valid ? CW'(1) : '0;
        end else if (ld_valid && !w_ld_full) begin
            w_ld_we        = 1'b1;
            w_ld_count_nxt = r_ld_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_count <= '0;
        end else begin
            r_ld_count <= w_ld_count_nxt;
        end
    end

    // Array contents are deliberately not reset; they are unreachable until
    // reloaded because the count returns to zero.
    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            r_mem[w_ld_addr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registered fetch. The array read sees pre-edge contents, so a rewrite
    // in the same cycle is not visible to this fetch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= NOP;
            r_rd_valid <= 1'b0;
            r_fault    <= c_fault_none;
        end else if (!stall) begin
            if (req) begin
                r_rd       <= (w_fault != c_fault_none) ? NOP
                                                        : r_mem[w_idx_x[MAW-1:0]];
                r_fault    <= w_fault;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;
    assign fault    = r_fault;
    assign ld_full  = w_ld_full;
    assign ld_count = r_ld_count;

endmodule

`default_nettype wire
